router_cfg_sequencer: RTL and testbench
=======================================

# router_cfg_sequencer

Context sequencer for the tile router. It holds a small context memory of crossbar-select, register-bypass and register-write-enable words. On start it replays those words cycle by cycle into the router's `i__sram_xbar_sel`, `regbypass` and `regWEN` inputs, for a programmed initiation interval and iteration count. It sits between the tile's configuration loader and the router, and is the only driver of the router's control inputs.

## Interface
- `NUM_CTX`, 16: context memory depth (power of two, ≥2); `LOG_CTX = $clog2(NUM_CTX)`.
- `NUM_INPUT_PORTS`, 6: router crossbar inputs.
- `NUM_OUTPUT_PORTS`, 7: router crossbar outputs.
- `CFG_W`, 50: context word width, computed as `NUM_OUTPUT_PORTS*NUM_INPUT_PORTS + 4 + 4`.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `i__cfg_wr_en` in 1: context write strobe.
- `i__cfg_wr_addr` in `LOG_CTX`: context write address.
- `i__cfg_wr_data` in `CFG_W`: context word. Layout:
  - `[6j+5:6j]`: select for output `j`; bit `k` selects input `k`.
  - `[45:42]`: regbypass.
  - `[49:46]`: regWEN.
- `i__start` in 1: launch pulse.
- `i__ii` in `LOG_CTX+1`: contexts per iteration, valid range 1..`NUM_CTX`.
- `i__iter_count` in 16: iterations to run; 0 means run until stop.
- `i__stall` in 1: hold the current context.
- `i__stop` in 1: abort.
- `o__xbar_sel` out `[NUM_INPUT_PORTS-1:0]` × `[NUM_OUTPUT_PORTS-1:0]` (unpacked): drives router `i__sram_xbar_sel`.
- `o__regbypass` out 4: drives router `regbypass`.
- `o__regWEN` out 4: drives router `regWEN`.
- `o__ctx_ptr` out `LOG_CTX`: index of the context currently presented.
- `o__busy` out 1: high in PRIME and RUN.
- `o__done` out 1: one-cycle completion pulse.
- `o__cfg_err` out 1: one-cycle pulse on an illegal write or start.

## Operation
States are IDLE, PRIME, RUN and DONE.

- **Reset value of every output:** 0. The state resets to IDLE, and the pointer and iteration counter reset to 0. Context memory is not reset; its contents are undefined until written.
- **IDLE:**
  - Control outputs are forced to 0.
  - `i__cfg_wr_en` writes `mem[i__cfg_wr_addr]` at the clock edge.
  - `i__start` with `i__ii` in 1..`NUM_CTX` latches `ii` and `iter_count`, clears the pointer and counter, and moves to PRIME.
  - `i__start` with `i__ii` = 0 or `i__ii` > `NUM_CTX` is ignored and pulses `o__cfg_err`.
- **PRIME:** reads `mem[0]` into the output register, then moves to RUN. Control outputs stay 0 during this cycle.
- **RUN:** the output register presents `mem[ctx_ptr]`. On each cycle that is not stalled:
  - The pointer advances.
  - At `ii-1` the pointer wraps to 0 and the iteration counter increments.
  - If the presented context is the last one of iteration `iter_count` (and `iter_count` ≠ 0), the next state is DONE.
- **DONE:** control outputs are 0 and `o__done` = 1 for one cycle, then the state returns to IDLE.
- **Stall:** while `i__stall` is high in RUN, `o__xbar_sel`, `o__regbypass` and `o__ctx_ptr` hold their values and `o__regWEN` is forced to 0, so router registers do not capture a repeated word. Stall has no effect in PRIME.
- **Stop:** `i__stop` in PRIME or RUN returns to IDLE on the next edge with outputs 0. No `o__done` pulse is generated.
- **Priority:** stop > stall > advance.
- **Illegal requests:**
  - A config write while `o__busy` or in DONE is dropped and pulses `o__cfg_err`.
  - `i__start` outside IDLE is ignored silently.
- **Write and start together in IDLE:** both take effect. The write is visible to PRIME's read.
- **Counter width:** 16 bits. When `iter_count` = 0 the counter wraps silently and the sequencer never self-terminates.

## Timing
- Start sampled at edge t:
  - PRIME from t+1.
  - First context on outputs from t+2.
  - `o__busy` high from t+1.
- Context n of iteration 0, with no stalls, appears at t+2+n.
- Total run with no stalls: `ii*iter_count` presented cycles, then one DONE cycle, then IDLE. `o__busy` falls in the same cycle `o__done` rises.
- `ii` = 1: the same word is presented every cycle, and the counter increments every non-stalled cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Asynchronous reset asserted mid-run zeroes all outputs immediately, without waiting for a clock edge.

## Structure
- Add to SMARTPkg:
  - `CFG_W` and the field offset constants.
  - `typedef enum logic [1:0] {SEQ_IDLE, SEQ_PRIME, SEQ_RUN, SEQ_DONE}`.
  - The packed `RouterCtx` struct (sel, regbypass, regWEN).
- Sub-module `router_ctx_mem`: `NUM_CTX`×`CFG_W` flop array with one synchronous write port and one combinational read port, no reset.
- The top level holds the FSM, pointer, iteration counter, output register and word unpacking.

## Test plan
- Reset mid-RUN: all outputs read 0 asynchronously; after release the state is IDLE and `o__busy` = 0.
- Write ctx0..2 with distinct selects (e.g. ctx0 routes input 0 to output 0, ctx1 input 1 to output 1, ctx2 input 2 to output 2); start with `ii`=3, `iter_count`=2:
  - ctx0,1,2,0,1,2 appear at t+2..t+7.
  - `o__done` pulses at t+8.
  - `o__busy` is 0 at t+8.
- Same program with `i__stall` high for 2 cycles while ctx1 is presented: ctx1 is held for 3 cycles with `o__regWEN` = 0 during the 2 stall cycles, and `o__done` moves to t+10.
- `ii`=1, `iter_count`=0, `i__stop` at cycle 20: ctx0 is presented continuously; outputs are 0 and the state is IDLE at 21, with no `o__done` pulse.
- Illegal requests:
  - Start with `ii`=0: `o__cfg_err` pulses for one cycle and the state stays IDLE.
  - Config write while busy: `o__cfg_err` pulses and memory is unchanged, checked by a rerun.
- In IDLE, write ctx0 = regWEN 4'hF in the same cycle as start with `ii`=1: the first presented word shows `o__regWEN` = 4'hF.

Source files
------------

// File: rtl/router_cfg_sequencer_pkg.sv
// Shared types and constants for the router context sequencer: context word
// layout, sequencer states and the unpacked router control word.
package router_cfg_sequencer_pkg;

    localparam int NUM_INPUT_PORTS  = 6;
    localparam int NUM_OUTPUT_PORTS = 7;
    localparam int SEL_W            = NUM_OUTPUT_PORTS * NUM_INPUT_PORTS;
    localparam int CFG_W            = SEL_W + 4 + 4;
    localparam int RB_LSB           = SEL_W;
    localparam int RWEN_LSB         = SEL_W + 4;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_PRIME = 2'd1,
        SEQ_RUN   = 2'd2,
        SEQ_DONE  = 2'd3
    } seq_state_e;

    typedef struct packed {
        logic [3:0]                                      regWEN;
        logic [3:0]                                      regbypass;
        logic [NUM_OUTPUT_PORTS-1:0][NUM_INPUT_PORTS-1:0] sel;
    } RouterCtx;

    // A held word must not be captured twice by the router registers.
    function automatic RouterCtx ctx_mute_wen(input RouterCtx c);
        RouterCtx m;
        m        = c;
        m.regWEN = 4'h0;
        return m;
    endfunction

endpackage

// File: rtl/router_cfg_sequencer_ctx_mem.sv
// Context memory: flop array with one synchronous write port and one
// combinational read port; deliberately not reset.
module router_ctx_mem
    import router_cfg_sequencer_pkg::*;
#(
    parameter int NUM_CTX = 16,
    parameter int LOG_CTX = $clog2(NUM_CTX)
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [LOG_CTX-1:0] wr_addr,
    input  logic [CFG_W-1:0]   wr_data,
    input  logic [LOG_CTX-1:0] rd_addr,
    output logic [CFG_W-1:0]   rd_data
);

    logic [CFG_W-1:0] mem_r [NUM_CTX];

    // Write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/router_cfg_sequencer.sv
// Context sequencer for the tile router: replays stored crossbar/bypass/WEN
// words into the router for a programmed initiation interval and iteration count.
module router_cfg_sequencer
    import router_cfg_sequencer_pkg::*;
#(
    parameter int NUM_CTX = 16,
    parameter int LOG_CTX = $clog2(NUM_CTX)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i__cfg_wr_en,
    input  logic [LOG_CTX-1:0]         i__cfg_wr_addr,
    input  logic [CFG_W-1:0]           i__cfg_wr_data,
    input  logic                       i__start,
    input  logic [LOG_CTX:0]           i__ii,
    input  logic [15:0]                i__iter_count,
    input  logic                       i__stall,
    input  logic                       i__stop,
    output logic [NUM_INPUT_PORTS-1:0] o__xbar_sel [NUM_OUTPUT_PORTS-1:0],
    output logic [3:0]                 o__regbypass,
    output logic [3:0]                 o__regWEN,
    output logic [LOG_CTX-1:0]         o__ctx_ptr,
    output logic                       o__busy,
    output logic                       o__done,
    output logic                       o__cfg_err
);

    localparam int II_W = LOG_CTX + 1;

    seq_state_e         state_r, state_nxt_s;
    logic [II_W-1:0]    ii_r, ii_nxt_s;
    logic [15:0]        lim_r, lim_nxt_s, iter_r, iter_nxt_s;
    logic [LOG_CTX-1:0] ptr_r, ptr_nxt_s, ptr_adv_s, rd_addr_s;
    RouterCtx           ctx_r, ctx_nxt_s, ctx_rd_s;
    logic               busy_r, busy_nxt_s, done_r, done_nxt_s, err_r, err_nxt_s;
    logic [CFG_W-1:0]   rd_data_s;
    logic               mem_we_s, ii_ok_s, wrap_s, last_s;

    assign mem_we_s  = i__cfg_wr_en && (state_r == SEQ_IDLE);
    assign ii_ok_s   = (i__ii != II_W'(0)) && (i__ii <= II_W'(NUM_CTX));
    assign wrap_s    = ({1'b0, ptr_r} == (ii_r - II_W'(1)));
    assign last_s    = wrap_s && (lim_r != 16'd0) && (iter_r == (lim_r - 16'd1));
    assign ptr_adv_s = wrap_s ? {LOG_CTX{1'b0}} : (ptr_r + LOG_CTX'(1));
    // PRIME always fetches context 0; RUN pre-fetches the word after the current one.
    assign rd_addr_s = (state_r == SEQ_RUN) ? ptr_adv_s : {LOG_CTX{1'b0}};

    router_ctx_mem #(.NUM_CTX(NUM_CTX), .LOG_CTX(LOG_CTX)) u_ctx_mem (
        .clk     (clk),
        .wr_en   (mem_we_s),
        .wr_addr (i__cfg_wr_addr),
        .wr_data (i__cfg_wr_data),
        .rd_addr (rd_addr_s),
        .rd_data (rd_data_s)
    );

    assign ctx_rd_s.sel       = rd_data_s[SEL_W-1:0];
    assign ctx_rd_s.regbypass = rd_data_s[RB_LSB +: 4];
    assign ctx_rd_s.regWEN    = rd_data_s[RWEN_LSB +: 4];

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= SEQ_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode; stop outranks stall, stall outranks advance
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            SEQ_IDLE: begin
                if (i__start && ii_ok_s) state_nxt_s = SEQ_PRIME;
                else                     state_nxt_s = SEQ_IDLE;
            end
            SEQ_PRIME: begin
                if (i__stop) state_nxt_s = SEQ_IDLE;
                else         state_nxt_s = SEQ_RUN;
            end
            SEQ_RUN: begin
                if (i__stop)       state_nxt_s = SEQ_IDLE;
                else if (i__stall) state_nxt_s = SEQ_RUN;
                else if (last_s)   state_nxt_s = SEQ_DONE;
                else               state_nxt_s = SEQ_RUN;
            end
            SEQ_DONE: state_nxt_s = SEQ_IDLE;
            default:  state_nxt_s = SEQ_IDLE;
        endcase
    end

    // Next values of the datapath and output registers
    always_comb begin
        ii_nxt_s   = ii_r;
        lim_nxt_s  = lim_r;
        iter_nxt_s = iter_r;
        ptr_nxt_s  = {LOG_CTX{1'b0}};
        ctx_nxt_s  = '0;
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
        err_nxt_s  = 1'b0;
        case (state_r)
            SEQ_IDLE: begin
                if (i__start && ii_ok_s) begin
                    ii_nxt_s   = i__ii;
                    lim_nxt_s  = i__iter_count;
                    iter_nxt_s = 16'd0;
                    busy_nxt_s = 1'b1;
                end else begin
                    err_nxt_s  = i__start;
                end
            end
            SEQ_PRIME: begin
                err_nxt_s = i__cfg_wr_en;
                if (i__stop) begin
                    busy_nxt_s = 1'b0;
                end else begin
                    ctx_nxt_s  = ctx_rd_s;
                    busy_nxt_s = 1'b1;
                end
            end
            SEQ_RUN: begin
                err_nxt_s = i__cfg_wr_en;
                if (i__stop) begin
                    busy_nxt_s = 1'b0;
                end else if (i__stall) begin
                    ptr_nxt_s  = ptr_r;
                    ctx_nxt_s  = ctx_mute_wen(ctx_r);
                    busy_nxt_s = 1'b1;
                end else if (last_s) begin
                    done_nxt_s = 1'b1;
                end else begin
                    ptr_nxt_s  = ptr_adv_s;
                    iter_nxt_s = wrap_s ? (iter_r + 16'd1) : iter_r;
                    ctx_nxt_s  = ctx_rd_s;
                    busy_nxt_s = 1'b1;
                end
            end
            SEQ_DONE: begin
                err_nxt_s = i__cfg_wr_en;
            end
            default: begin
                err_nxt_s = 1'b0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ii_r   <= II_W'(0);
            lim_r  <= 16'd0;
            iter_r <= 16'd0;
            ptr_r  <= {LOG_CTX{1'b0}};
            ctx_r  <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            ii_r   <= ii_nxt_s;
            lim_r  <= lim_nxt_s;
            iter_r <= iter_nxt_s;
            ptr_r  <= ptr_nxt_s;
            ctx_r  <= ctx_nxt_s;
            busy_r <= busy_nxt_s;
            done_r <= done_nxt_s;
            err_r  <= err_nxt_s;
        end
    end

    // Present the registered word in the router's per-output select shape
    always_comb begin
        for (int j = 0; j < NUM_OUTPUT_PORTS; j++) begin
            o__xbar_sel[j] = ctx_r.sel[j];
        end
    end

    assign o__regbypass = ctx_r.regbypass;
    assign o__regWEN    = ctx_r.regWEN;
    assign o__ctx_ptr   = ptr_r;
    assign o__busy      = busy_r;
    assign o__done      = done_r;
    assign o__cfg_err   = err_r;

endmodule

// File: tb/tb_router_cfg_sequencer.sv
// Directed self-checking bench for router_cfg_sequencer.
module tb_router_cfg_sequencer;

    localparam int NUM_CTX = 16;
    localparam int LOG_CTX = 4;

    logic              clk;
    logic              reset;
    logic              i__cfg_wr_en;
    logic [3:0]        i__cfg_wr_addr;
    logic [49:0]       i__cfg_wr_data;
    logic              i__start;
    logic [4:0]        i__ii;
    logic [15:0]       i__iter_count;
    logic              i__stall;
    logic              i__stop;
    logic [5:0]        o__xbar_sel [6:0];
    logic [3:0]        o__regbypass;
    logic [3:0]        o__regWEN;
    logic [3:0]        o__ctx_ptr;
    logic              o__busy;
    logic              o__done;
    logic              o__cfg_err;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [49:0] w [3];
    logic [49:0] w_f;
    logic [49:0] junk;
    logic        saw_done;

    router_cfg_sequencer #(.NUM_CTX(NUM_CTX), .LOG_CTX(LOG_CTX)) dut (
        .clk            (clk),
        .reset          (reset),
        .i__cfg_wr_en   (i__cfg_wr_en),
        .i__cfg_wr_addr (i__cfg_wr_addr),
        .i__cfg_wr_data (i__cfg_wr_data),
        .i__start       (i__start),
        .i__ii          (i__ii),
        .i__iter_count  (i__iter_count),
        .i__stall       (i__stall),
        .i__stop        (i__stop),
        .o__xbar_sel    (o__xbar_sel),
        .o__regbypass   (o__regbypass),
        .o__regWEN      (o__regWEN),
        .o__ctx_ptr     (o__ctx_ptr),
        .o__busy        (o__busy),
        .o__done        (o__done),
        .o__cfg_err     (o__cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [49:0] obs_word();
        logic [49:0] r;
        r = 50'd0;
        for (int j = 0; j < 7; j++) r[j*6 +: 6] = o__xbar_sel[j];
        r[45:42] = o__regbypass;
        r[49:46] = o__regWEN;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [49:0] d);
        i__cfg_wr_en   = 1'b1;
        i__cfg_wr_addr = a;
        i__cfg_wr_data = d;
        step();
        i__cfg_wr_en   = 1'b0;
    endtask

    // Drives start for one edge; on return the DUT is one edge past the launch.
    task automatic start_run(input logic [4:0] ii, input logic [15:0] iters);
        i__ii         = ii;
        i__iter_count = iters;
        i__start      = 1'b1;
        step();
        i__start      = 1'b0;
    endtask

    initial begin
        int exp_idx [8];
        logic [49:0] e;

        reset = 1'b1; i__cfg_wr_en = 1'b0; i__cfg_wr_addr = 4'd0; i__cfg_wr_data = 50'd0;
        i__start = 1'b0; i__ii = 5'd0; i__iter_count = 16'd0; i__stall = 1'b0; i__stop = 1'b0;
        w[0] = {4'h3, 4'h1, 42'd1 << 0};
        w[1] = {4'h5, 4'h2, 42'd1 << 7};
        w[2] = {4'h6, 4'h4, 42'd1 << 14};
        w_f  = {4'hF, w[0][45:0]};
        junk = {4'h9, 4'h9, 42'h3FF_FFFF_FFFF};

        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_word", obs_word(), 64'd0);
        check_eq("rst_busy", o__busy, 64'd0);
        check_eq("rst_flags", {o__done, o__cfg_err, o__ctx_ptr}, 64'd0);
        reset = 1'b0;
        step();

        for (int i = 0; i < 3; i++) cfg_write(4'(i), w[i]);
        check_eq("wr_idle_err", o__cfg_err, 64'd0);

        // Plain run: ii=3, two iterations
        start_run(5'd3, 16'd2);
        check_eq("a_prime_busy", o__busy, 64'd1);
        check_eq("a_prime_word", obs_word(), 64'd0);
        for (int k = 1; k <= 6; k++) begin
            step();
            check_eq($sformatf("a_word%0d", k), obs_word(), w[(k-1)%3]);
            check_eq($sformatf("a_ptr%0d", k), o__ctx_ptr, 64'((k-1)%3));
            check_eq($sformatf("a_busy%0d", k), {o__busy, o__done}, 64'd2);
        end
        step();
        check_eq("a_done", {o__busy, o__done}, 64'd1);
        check_eq("a_done_word", obs_word(), 64'd0);
        step();
        check_eq("a_idle", {o__busy, o__done}, 64'd0);

        // Same program with a two-cycle stall on ctx1
        exp_idx = '{0, 1, 1, 1, 2, 0, 1, 2};
        start_run(5'd3, 16'd2);
        for (int k = 1; k <= 8; k++) begin
            step();
            e = w[exp_idx[k-1]];
            if (k == 3 || k == 4) e[49:46] = 4'h0;
            check_eq($sformatf("b_word%0d", k), obs_word(), e);
            check_eq($sformatf("b_ptr%0d", k), o__ctx_ptr, 64'(exp_idx[k-1]));
            check_eq($sformatf("b_done%0d", k), o__done, 64'd0);
            if (k == 2) i__stall = 1'b1;
            if (k == 4) i__stall = 1'b0;
        end
        step();
        check_eq("b_done", {o__busy, o__done}, 64'd1);
        step();

        // Asynchronous reset in the middle of a run
        start_run(5'd3, 16'd0);
        step();
        step();
        check_eq("r_pre_word", obs_word(), w[1]);
        #2 reset = 1'b1;
        #1;
        check_eq("r_async_word", obs_word(), 64'd0);
        check_eq("r_async_flags", {o__busy, o__done, o__cfg_err, o__ctx_ptr}, 64'd0);
        step();
        reset = 1'b0;
        step();
        check_eq("r_after_busy", {o__busy, o__done}, 64'd0);

        // ii=1, endless, stopped
        saw_done = 1'b0;
        start_run(5'd1, 16'd0);
        for (int k = 1; k <= 19; k++) begin
            step();
            saw_done = saw_done | o__done;
            check_eq($sformatf("s_word%0d", k), obs_word(), w[0]);
        end
        check_eq("s_ptr", o__ctx_ptr, 64'd0);
        i__stop = 1'b1;
        step();
        i__stop = 1'b0;
        check_eq("s_stop_word", obs_word(), 64'd0);
        check_eq("s_stop_busy", {o__busy, o__done}, 64'd0);
        step();
        saw_done = saw_done | o__done;
        check_eq("s_no_done", saw_done, 64'd0);

        // Illegal starts: ii=0 and ii=NUM_CTX+1
        start_run(5'd0, 16'd1);
        check_eq("e_ii0_err", {o__cfg_err, o__busy}, 64'd2);
        step();
        check_eq("e_ii0_clear", {o__cfg_err, o__busy}, 64'd0);
        start_run(5'd17, 16'd1);
        check_eq("e_ii17_err", {o__cfg_err, o__busy}, 64'd2);
        step();

        // Config write while busy is dropped
        start_run(5'd3, 16'd1);
        step();
        i__cfg_wr_en = 1'b1; i__cfg_wr_addr = 4'd1; i__cfg_wr_data = junk;
        step();
        i__cfg_wr_en = 1'b0;
        check_eq("e_busy_wr_err", o__cfg_err, 64'd1);
        check_eq("e_busy_word", obs_word(), w[1]);
        step();
        check_eq("e_err_clear", o__cfg_err, 64'd0);
        step();
        check_eq("e_done", o__done, 64'd1);
        step();
        start_run(5'd3, 16'd1);
        step();
        step();
        check_eq("e_mem_kept", obs_word(), w[1]);
        repeat (3) step();

        // Write and start together in IDLE
        i__cfg_wr_en = 1'b1; i__cfg_wr_addr = 4'd0; i__cfg_wr_data = w_f;
        start_run(5'd1, 16'd1);
        i__cfg_wr_en = 1'b0;
        check_eq("ws_prime_word", obs_word(), 64'd0);
        check_eq("ws_err", o__cfg_err, 64'd0);
        step();
        check_eq("ws_wen", o__regWEN, 64'hF);
        check_eq("ws_word", obs_word(), w_f);
        step();
        check_eq("ws_done", {o__busy, o__done}, 64'd1);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
